// File: rtl/apuracao_votos.sv
// apuracao_votos: day-vote sequencer.
// Collects one vote per living player, tallies and resolves the majority.
module apuracao_votos #(
    parameter int N_JOG = 5,
    parameter int W_IDX = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic [N_JOG-1:0] vivos,
    input  logic [W_IDX-1:0] lobo_idx,
    input  logic             voto_valido,
    input  logic [W_IDX-1:0] voto_alvo,
    output logic [W_IDX-1:0] votante,
    output logic             ocupado,
    output logic             erro_voto,
    output logic             pronto,
    output logic [W_IDX-1:0] eleito,
    output logic             empate,
    output logic             acertou,
    output logic [2:0]       db_estado
);

    localparam int NIDX = 2 ** W_IDX;
    localparam logic [W_IDX-1:0] NENHUM = '1;
    localparam logic [W_IDX-1:0] FIMPTR = W_IDX'(N_JOG);
    localparam logic [W_IDX-1:0] ULTIMO = W_IDX'(N_JOG - 1);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        BUSCA    = 3'd1,
        ESPERA   = 3'd2,
        REGISTRA = 3'd3,
        APURA    = 3'd4,
        FIM      = 3'd5
    } estado_t;

    estado_t estado, prox;

    logic [N_JOG-1:0] vivos_r;
    logic [NIDX-1:0]  vivos_ext;
    logic [W_IDX-1:0] lobo_r;
    logic [W_IDX-1:0] ptr;
    logic [W_IDX-1:0] alvo_r;
    logic [2:0]       tally [N_JOG];
    logic [W_IDX-1:0] idx;
    logic [2:0]       max_r;
    logic [W_IDX-1:0] arg_r;
    logic             tie_r;
    logic             erro_r;
    logic [W_IDX-1:0] eleito_r;
    logic             empate_r;
    logic             acertou_r;

    logic             rejeita;
    logic             aceita;
    logic [2:0]       n_max;
    logic [W_IDX-1:0] n_arg;
    logic             n_tie;
    logic             sem_vencedor;

    // Out-of-range indices read as dead players.
    assign vivos_ext = NIDX'(vivos_r);

    // Classify the offered vote against the latched alive mask.
    always_comb begin
        rejeita = (voto_alvo >= FIMPTR)
                | ~vivos_ext[voto_alvo]
                | (voto_alvo == ptr);
        aceita  = (estado == ESPERA) & voto_valido & ~rejeita;
    end

    // One step of the majority scan over the current index.
    always_comb begin
        n_max = max_r;
        n_arg = arg_r;
        n_tie = tie_r;
        if (tally[idx] > max_r) begin
            n_max = tally[idx];
            n_arg = idx;
            n_tie = 1'b0;
        end else if (tally[idx] == max_r && max_r != 3'd0) begin
            n_tie = 1'b1;
        end
        sem_vencedor = (n_max == 3'd0) | n_tie;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox;
    end

    // Next-state logic.
    always_comb begin
        prox = estado;
        unique case (estado)
            OCIOSO:   if (iniciar) prox = BUSCA;
            BUSCA: begin
                if (ptr == FIMPTR)       prox = APURA;
                else if (vivos_ext[ptr]) prox = ESPERA;
            end
            ESPERA:   if (aceita) prox = REGISTRA;
            REGISTRA: prox = BUSCA;
            APURA:    if (idx == ULTIMO) prox = FIM;
            FIM:      prox = OCIOSO;
            default:  prox = OCIOSO;
        endcase
    end

    // Round datapath: pointer, tallies, scan and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            vivos_r   <= '0;
            lobo_r    <= '0;
            ptr       <= '0;
            alvo_r    <= '0;
            idx       <= '0;
            max_r     <= '0;
            arg_r     <= '0;
            tie_r     <= 1'b0;
            erro_r    <= 1'b0;
            eleito_r  <= NENHUM;
            empate_r  <= 1'b0;
            acertou_r <= 1'b0;
            for (int i = 0; i < N_JOG; i++) tally[i] <= '0;
        end else begin
            erro_r <= (estado == ESPERA) & voto_valido & rejeita;
            unique case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        vivos_r <= vivos;
                        lobo_r  <= lobo_idx;
                        ptr     <= '0;
                        for (int i = 0; i < N_JOG; i++) tally[i] <= '0;
                    end
                end
                BUSCA: begin
                    if (ptr == FIMPTR) begin
                        idx   <= '0;
                        max_r <= '0;
                        arg_r <= '0;
                        tie_r <= 1'b0;
                    end else if (!vivos_ext[ptr]) begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ESPERA: if (aceita) alvo_r <= voto_alvo;
                REGISTRA: begin
                    tally[alvo_r] <= tally[alvo_r] + 3'd1;
                    ptr           <= ptr + 1'b1;
                end
                APURA: begin
                    idx   <= idx + 1'b1;
                    max_r <= n_max;
                    arg_r <= n_arg;
                    tie_r <= n_tie;
                    if (idx == ULTIMO) begin
                        eleito_r  <= sem_vencedor ? NENHUM : n_arg;
                        empate_r  <= sem_vencedor;
                        acertou_r <= ~sem_vencedor & (n_arg == lobo_r);
                    end
                end
                default: ;
            endcase
        end
    end

    assign votante   = (estado == ESPERA) ? ptr : NENHUM;
    assign ocupado   = (estado != OCIOSO);
    assign pronto    = (estado == FIM);
    assign erro_voto = erro_r;
    assign eleito    = eleito_r;
    assign empate    = empate_r;
    assign acertou   = acertou_r;
    assign db_estado = estado;

endmodule

// File: tb/tb_apuracao_votos.sv
// tb_apuracao_votos: directed scenarios plus random rounds
// checked against a vote-counting model.
module tb_apuracao_votos;

    localparam int N = 5;
    localparam logic [2:0] NENHUM = 3'b111;

    logic         clock = 1'b0;
    logic         reset;
    logic         iniciar;
    logic [N-1:0] vivos;
    logic [2:0]   lobo_idx;
    logic         voto_valido;
    logic [2:0]   voto_alvo;
    logic [2:0]   votante;
    logic         ocupado;
    logic         erro_voto;
    logic         pronto;
    logic [2:0]   eleito;
    logic         empate;
    logic         acertou;
    logic [2:0]   db_estado;

    apuracao_votos #(.N_JOG(N), .W_IDX(3)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .vivos(vivos), .lobo_idx(lobo_idx),
        .voto_valido(voto_valido), .voto_alvo(voto_alvo),
        .votante(votante), .ocupado(ocupado),
        .erro_voto(erro_voto), .pronto(pronto),
        .eleito(eleito), .empate(empate), .acertou(acertou),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int total = 0;
    int passed = 0;

    logic [2:0] plano [N];
    logic [2:0] seq_q [$];
    int         r_pronto, r_lat;
    logic [2:0] r_el;
    logic       r_emp, r_ac, r_timeout, r_ocup1;

    logic [2:0] m_el;
    logic       m_emp, m_ac;

    // Reference: count votes of alive players, majority must be unique.
    task automatic modelo(input logic [N-1:0] v, input logic [2:0] l);
        int cnt [N];
        int mx, nmx, arg;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int i = 0; i < N; i++) if (v[i]) cnt[plano[i]]++;
        mx = 0; arg = 0;
        for (int i = 0; i < N; i++) if (cnt[i] > mx) begin mx = cnt[i]; arg = i; end
        nmx = 0;
        for (int i = 0; i < N; i++) if (cnt[i] == mx) nmx++;
        m_emp = (mx == 0) || (nmx > 1);
        m_el  = m_emp ? NENHUM : 3'(arg);
        m_ac  = !m_emp && (m_el == l);
    endtask

    // Play one full round: each awaited voter casts plano[votante].
    task automatic rodada(input logic [N-1:0] v, input logic [2:0] l);
        int extra;
        r_pronto = 0; r_lat = 0; r_timeout = 1'b1; extra = 0;
        seq_q.delete();
        @(negedge clock);
        vivos = v; lobo_idx = l; iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        r_ocup1 = ocupado;
        for (int c = 1; c < 300; c++) begin
            if (pronto) begin
                r_pronto++;
                if (r_pronto == 1) begin
                    r_el = eleito; r_emp = empate; r_ac = acertou;
                    r_lat = c; r_timeout = 1'b0;
                end
            end
            if (voto_valido) voto_valido = 1'b0;
            else if (votante != NENHUM) begin
                seq_q.push_back(votante);
                voto_alvo = plano[int'(votante)];
                voto_valido = 1'b1;
            end
            if (r_pronto > 0) begin
                extra++;
                if (extra > 3) break;
            end
            @(negedge clock);
        end
        voto_valido = 1'b0;
    endtask

    task automatic espera_votante(input logic [2:0] alvo, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (votante == alvo) begin ok = 1'b1; break; end
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if ({db_estado, ocupado, pronto, erro_voto, empate, acertou, votante, eleito}
            !== {3'd0, 5'b0, NENHUM, NENHUM}) begin
            $display("FAIL reset: got st=%0d oc=%b pr=%b er=%b em=%b ac=%b vt=%0d el=%0d want 0,0,0,0,0,0,7,7",
                     db_estado, ocupado, pronto, erro_voto, empate, acertou, votante, eleito);
        end else passed++;
        reset = 1'b0;
    endtask

    task automatic test_maioria;
        plano = '{3'd2, 3'd2, 3'd0, 3'd2, 3'd1};
        rodada(5'b11111, 3'd2);
        total++;
        if (r_timeout || r_pronto != 1 || r_ocup1 !== 1'b1) begin
            $display("FAIL maioria_pronto: got timeout=%b pronto=%0d ocup=%b want 0,1,1",
                     r_timeout, r_pronto, r_ocup1);
        end else passed++;
        total++;
        if ({r_el, r_emp, r_ac} !== {3'd2, 1'b0, 1'b1})
            $display("FAIL maioria_result: got el=%0d em=%b ac=%b want 2,0,1", r_el, r_emp, r_ac);
        else passed++;
        total++;
        if (seq_q.size() != 5 || seq_q[0] != 0 || seq_q[4] != 4)
            $display("FAIL maioria_seq: got size=%0d want 5 voters 0..4", seq_q.size());
        else passed++;
        @(negedge clock);
        total++;
        if ({eleito, empate, acertou} !== {3'd2, 1'b0, 1'b1})
            $display("FAIL maioria_hold: got el=%0d em=%b ac=%b want 2,0,1", eleito, empate, acertou);
        else passed++;
    endtask

    task automatic test_pulados;
        plano = '{3'd0, 3'd2, 3'd1, 3'd0, 3'd1};
        rodada(5'b10110, 3'd4);
        total++;
        if (seq_q.size() != 3 || seq_q[0] != 1 || seq_q[1] != 2 || seq_q[2] != 4)
            $display("FAIL pulados_seq: got size=%0d want voters 1,2,4", seq_q.size());
        else passed++;
        total++;
        if (r_timeout || {r_el, r_emp, r_ac} !== {3'd1, 1'b0, 1'b0})
            $display("FAIL pulados_result: got el=%0d em=%b ac=%b to=%b want 1,0,0,0",
                     r_el, r_emp, r_ac, r_timeout);
        else passed++;
    endtask

    task automatic test_empate;
        plano = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        rodada(5'b00011, 3'd0);
        total++;
        if (r_timeout || {r_el, r_emp, r_ac} !== {NENHUM, 1'b1, 1'b0})
            $display("FAIL empate_result: got el=%0d em=%b ac=%b to=%b want 7,1,0,0",
                     r_el, r_emp, r_ac, r_timeout);
        else passed++;
    endtask

    task automatic test_sem_vivos;
        rodada(5'b00000, 3'd1);
        total++;
        if (r_timeout || r_lat != 2 * N + 2 || r_pronto != 1)
            $display("FAIL sem_vivos_lat: got lat=%0d pronto=%0d want %0d,1",
                     r_lat, r_pronto, 2 * N + 2);
        else passed++;
        total++;
        if ({r_el, r_emp, r_ac} !== {NENHUM, 1'b1, 1'b0})
            $display("FAIL sem_vivos_result: got el=%0d em=%b ac=%b want 7,1,0", r_el, r_emp, r_ac);
        else passed++;
    endtask

    task automatic test_rejeicao;
        logic [2:0] ruins [3];
        logic ok;
        int erros;
        ruins = '{3'd0, 3'd7, 3'd3};
        erros = 0;
        @(negedge clock);
        vivos = 5'b10111; lobo_idx = 3'd0; iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        espera_votante(3'd0, ok);
        for (int k = 0; k < 3; k++) begin
            voto_alvo = ruins[k]; voto_valido = 1'b1;
            @(negedge clock);
            voto_valido = 1'b0;
            if (erro_voto === 1'b1 && votante === 3'd0) erros++;
            @(negedge clock);
            if (erro_voto !== 1'b0) erros = -10;
        end
        total++;
        if (!ok || erros != 3)
            $display("FAIL rejeicao_erros: got %0d clean rejects want 3 (ok=%b)", erros, ok);
        else passed++;
        voto_alvo = 3'd1; voto_valido = 1'b1;
        @(negedge clock);
        voto_valido = 1'b0;
        total++;
        if (erro_voto !== 1'b0 || db_estado !== 3'd3)
            $display("FAIL rejeicao_aceite: got erro=%b st=%0d want 0,3", erro_voto, db_estado);
        else passed++;
        espera_votante(3'd1, ok);
        total++;
        if (!ok) $display("FAIL rejeicao_avanco: got votante=%0d want 1", votante);
        else passed++;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset_meio;
        logic ok;
        int np;
        np = 0;
        @(negedge clock);
        vivos = 5'b11111; lobo_idx = 3'd2; iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        for (int v = 0; v < 3; v++) begin
            espera_votante(3'(v), ok);
            voto_alvo = (v == 1) ? 3'd0 : 3'd1; voto_valido = 1'b1;
            @(negedge clock);
            voto_valido = 1'b0;
        end
        espera_votante(3'd3, ok);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++;
        if (!ok || db_estado !== 3'd0 || ocupado !== 1'b0 || votante !== NENHUM)
            $display("FAIL reset_meio: got st=%0d oc=%b vt=%0d ok=%b want 0,0,7,1",
                     db_estado, ocupado, votante, ok);
        else passed++;
        for (int c = 0; c < 12; c++) begin
            if (pronto) np++;
            @(negedge clock);
        end
        total++;
        if (np != 0) $display("FAIL reset_meio_pronto: got %0d pulses want 0", np);
        else passed++;
        plano = '{3'd2, 3'd2, 3'd0, 3'd2, 3'd1};
        rodada(5'b11111, 3'd2);
        total++;
        if (r_timeout || {r_el, r_emp, r_ac} !== {3'd2, 1'b0, 1'b1})
            $display("FAIL reset_meio_limpo: got el=%0d em=%b ac=%b want 2,0,1", r_el, r_emp, r_ac);
        else passed++;
    endtask

    task automatic test_ignorados;
        logic ok;
        @(negedge clock);
        vivos = 5'b11111; lobo_idx = 3'd3; iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        espera_votante(3'd0, ok);
        vivos = 5'b00001; iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        total++;
        if (!ok || db_estado !== 3'd2 || votante !== 3'd0)
            $display("FAIL ignora_iniciar: got st=%0d vt=%0d want 2,0", db_estado, votante);
        else passed++;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        plano = '{3'd3, 3'd3, 3'd3, 3'd0, 3'd3};
        rodada(5'b11111, 3'd3);
        total++;
        if (r_timeout || {r_el, r_emp, r_ac} !== {3'd3, 1'b0, 1'b1})
            $display("FAIL ignora_rodada: got el=%0d em=%b ac=%b want 3,0,1", r_el, r_emp, r_ac);
        else passed++;
        voto_alvo = 3'd1; voto_valido = 1'b1;
        repeat (3) @(negedge clock);
        voto_valido = 1'b0;
        total++;
        if (db_estado !== 3'd0 || erro_voto !== 1'b0 || eleito !== 3'd3 || acertou !== 1'b1)
            $display("FAIL ignora_voto: got st=%0d er=%b el=%0d ac=%b want 0,0,3,1",
                     db_estado, erro_voto, eleito, acertou);
        else passed++;
    endtask

    task automatic test_aleatorio;
        logic [N-1:0] v;
        logic [2:0] l;
        int vivos_q [$];
        for (int r = 0; r < 25; r++) begin
            do v = N'($urandom_range(0, 31)); while ($countones(v) == 1);
            l = 3'($urandom_range(0, N - 1));
            vivos_q.delete();
            for (int i = 0; i < N; i++) if (v[i]) vivos_q.push_back(i);
            for (int i = 0; i < N; i++) begin
                int t;
                plano[i] = 3'd0;
                if (v[i]) begin
                    do t = vivos_q[$urandom_range(0, vivos_q.size() - 1)]; while (t == i);
                    plano[i] = 3'(t);
                end
            end
            modelo(v, l);
            rodada(v, l);
            total++;
            if (r_timeout || r_pronto != 1 || {r_el, r_emp, r_ac} !== {m_el, m_emp, m_ac})
                $display("FAIL aleatorio_%0d: got el=%0d em=%b ac=%b np=%0d want el=%0d em=%b ac=%b np=1",
                         r, r_el, r_emp, r_ac, r_pronto, m_el, m_emp, m_ac);
            else passed++;
            total++;
            if (seq_q.size() != vivos_q.size())
                $display("FAIL aleatorio_seq_%0d: got %0d voters want %0d",
                         r, seq_q.size(), vivos_q.size());
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; vivos = '0; lobo_idx = '0;
        voto_valido = 1'b0; voto_alvo = '0;
        test_reset;
        test_maioria;
        test_pulados;
        test_empate;
        test_sem_vivos;
        test_rejeicao;
        test_reset_meio;
        test_ignorados;
        test_aleatorio;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
